// File: rtl/fv_bank_cntl_param_if.sv
// Request bus shared by the write-back path and the Edge-PE read clients.
// The client side drives the request, the bank controller answers with ready.
interface fv_bank_cntl_param_if #(
    parameter int DATA_W = 64,
    parameter int NODE_W = 8,
    parameter int TAG_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [NODE_W-1:0] req_node_id;
    logic [TAG_W-1:0]  req_pe_tag;
    logic [DATA_W-1:0] req_data;
    logic              req_wr_eos;

    modport master (
        output req_valid,
        output req_wr,
        output req_node_id,
        output req_pe_tag,
        output req_data,
        output req_wr_eos,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_wr,
        input  req_node_id,
        input  req_pe_tag,
        input  req_data,
        input  req_wr_eos,
        output req_ready
    );
endinterface

// File: rtl/fv_bank_cntl_param.sv
// Feature-value SRAM bank controller.
// Streams every node of the current replay iteration to the small-FV streamer once
// per iteration, then serves write-back bursts and Edge-PE read bursts over a
// ready/valid request bus. SRAM reads have one cycle of latency; read beats come
// out valid-qualified one cycle after the strobe.
module fv_bank_cntl_param #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 10,
    parameter int FV_PER_LINE    = 2,
    parameter int LINES_PER_NODE = 8,
    parameter int NODES_PER_ITER = 4,
    parameter int NUM_BANKS      = 4,
    parameter int NUM_PE         = 4,
    parameter int NODE_W         = 8,
    parameter int ITER_W         = 4,
    parameter int FVNUM_W        = 5,
    localparam int TAG_W         = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ITER_W-1:0]   replay_iter,
    input  logic                update_phase,
    input  logic [FVNUM_W-1:0]  fv_num,
    fv_bank_cntl_param_if.slave req_if,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                sm_valid,
    output logic                sm_sos,
    output logic                sm_eos,
    output logic [ADDR_W-1:0]   sm_addr,
    output logic [DATA_W-1:0]   sm_data,
    output logic                pe_valid,
    output logic                pe_sos,
    output logic                pe_eos,
    output logic [TAG_W-1:0]    pe_tag,
    output logic [DATA_W-1:0]   pe_data,
    output logic                wr_overflow,
    output logic                busy
);

    localparam int FPL_SH  = $clog2(FV_PER_LINE);
    localparam int LPN_SH  = $clog2(LINES_PER_NODE);
    localparam int NPI_SH  = $clog2(NODES_PER_ITER);
    localparam int BANK_SH = $clog2(NUM_BANKS);
    localparam int LCNT_W  = LPN_SH + 1;                  // holds 0..LINES_PER_NODE
    localparam int NCNT_W  = (NPI_SH > 0) ? NPI_SH : 1;

    typedef enum logic [1:0] {IDLE, STREAM, WB, RD} state_t;

    state_t state_q, state_d;

    // Stream bookkeeping
    logic              run_q;
    logic              streamed_q;
    logic [ITER_W-1:0] last_iter_q;
    logic [ADDR_W-1:0] iter_base_q;
    logic [LCNT_W-1:0] sm_nlines_q;
    logic [NCNT_W-1:0] sm_node_q;
    logic [LCNT_W-1:0] sm_line_q;

    // Write-back / PE-read bookkeeping (the two bursts never overlap)
    logic [ADDR_W-1:0] op_base_q;
    logic [LCNT_W-1:0] op_cnt_q;
    logic [LCNT_W-1:0] rd_nlines_q;
    logic [TAG_W-1:0]  rd_tag_q;
    logic              ovf_q;

    // Read-return pipeline stage
    logic              out_vld_q, out_pe_q, out_sos_q, out_eos_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [TAG_W-1:0]  out_tag_q;

    // Derived values
    logic [FVNUM_W:0]  fv_ceil;
    logic [LCNT_W-1:0] nlines_cur;
    logic [ADDR_W-1:0] node_base;
    logic [ADDR_W-1:0] iter_base_cur;
    logic [ADDR_W-1:0] sm_issue_addr;
    logic              sm_last_line, sm_last_node;
    logic              stream_go;

    // FSM decode outputs
    logic              req_ready_c;
    logic              cen_c, wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic              issue_c, issue_pe_c, issue_sos_c, issue_eos_c;
    logic [TAG_W-1:0]  issue_tag_c;
    logic              wr_first_c, rd_first_c, wb_beat_c, ovf_set_c;

    // Lines per node from fv_num: ceiling divide, clamp, and 0 meaning a full node.
    assign fv_ceil    = ({1'b0, fv_num} + (FVNUM_W+1)'(FV_PER_LINE - 1)) >> FPL_SH;
    assign nlines_cur = (fv_num == '0 || int'(fv_ceil) >= LINES_PER_NODE)
                        ? LCNT_W'(LINES_PER_NODE) : LCNT_W'(fv_ceil);

    // Address arithmetic wraps at 2^ADDR_W by construction of the widths.
    assign node_base     = ADDR_W'(req_if.req_node_id >> BANK_SH) << LPN_SH;
    assign iter_base_cur = ADDR_W'(replay_iter) << (NPI_SH + LPN_SH);
    assign sm_issue_addr = iter_base_q + (ADDR_W'(sm_node_q) << LPN_SH) + ADDR_W'(sm_line_q);
    assign sm_last_line  = (sm_line_q == sm_nlines_q - LCNT_W'(1));
    assign sm_last_node  = (sm_node_q == NCNT_W'(NODES_PER_ITER - 1));

    // An iteration streams once: first time after reset, then on every iteration change.
    assign stream_go = (state_q == IDLE) && !update_phase &&
                       (!streamed_q || (replay_iter != last_iter_q));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode plus the SRAM strobe, ready and read-issue controls.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        req_ready_c = 1'b0;
        cen_c       = 1'b1;
        wen_c       = 1'b1;
        addr_c      = '0;
        wdata_c     = '0;
        issue_c     = 1'b0;
        issue_pe_c  = 1'b0;
        issue_sos_c = 1'b0;
        issue_eos_c = 1'b0;
        issue_tag_c = '0;
        wr_first_c  = 1'b0;
        rd_first_c  = 1'b0;
        wb_beat_c   = 1'b0;
        ovf_set_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (stream_go) begin
                    state_d = STREAM;
                end else if (update_phase && run_q) begin
                    // run_q keeps ready and strobes low while reset is asserted.
                    req_ready_c = 1'b1;
                    if (req_if.req_valid) begin
                        cen_c  = 1'b0;
                        addr_c = node_base;
                        if (req_if.req_wr) begin
                            wr_first_c = 1'b1;
                            wen_c      = 1'b0;
                            wdata_c    = req_if.req_data;
                            if (!req_if.req_wr_eos) state_d = WB;
                        end else begin
                            rd_first_c  = 1'b1;
                            issue_c     = 1'b1;
                            issue_pe_c  = 1'b1;
                            issue_sos_c = 1'b1;
                            issue_eos_c = (nlines_cur == LCNT_W'(1));
                            issue_tag_c = req_if.req_pe_tag;
                            if (nlines_cur != LCNT_W'(1)) state_d = RD;
                        end
                    end
                end
            end
            STREAM: begin
                cen_c       = 1'b0;
                addr_c      = sm_issue_addr;
                issue_c     = 1'b1;
                issue_sos_c = (sm_node_q == '0) && (sm_line_q == '0);
                issue_eos_c = sm_last_node && sm_last_line;
                if (sm_last_node && sm_last_line) state_d = IDLE;
            end
            WB: begin
                req_ready_c = 1'b1;
                if (req_if.req_valid) begin
                    wb_beat_c = 1'b1;
                    if (op_cnt_q < LCNT_W'(LINES_PER_NODE)) begin
                        cen_c   = 1'b0;
                        wen_c   = 1'b0;
                        addr_c  = op_base_q + ADDR_W'(op_cnt_q);
                        wdata_c = req_if.req_data;
                    end else begin
                        ovf_set_c = 1'b1;
                    end
                    if (req_if.req_wr_eos) state_d = IDLE;
                end
            end
            RD: begin
                cen_c       = 1'b0;
                addr_c      = op_base_q + ADDR_W'(op_cnt_q);
                issue_c     = 1'b1;
                issue_pe_c  = 1'b1;
                issue_tag_c = rd_tag_q;
                issue_eos_c = (op_cnt_q == rd_nlines_q - LCNT_W'(1));
                if (op_cnt_q == rd_nlines_q - LCNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst counters, latched bases and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q       <= 1'b0;
            streamed_q  <= 1'b0;
            last_iter_q <= '0;
            iter_base_q <= '0;
            sm_nlines_q <= '0;
            sm_node_q   <= '0;
            sm_line_q   <= '0;
            op_base_q   <= '0;
            op_cnt_q    <= '0;
            rd_nlines_q <= '0;
            rd_tag_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (stream_go) begin
                streamed_q  <= 1'b1;
                last_iter_q <= replay_iter;
                iter_base_q <= iter_base_cur;
                sm_nlines_q <= nlines_cur;
                sm_node_q   <= '0;
                sm_line_q   <= '0;
            end
            if (state_q == STREAM) begin
                if (sm_last_line) begin
                    sm_line_q <= '0;
                    sm_node_q <= sm_node_q + NCNT_W'(1);
                end else begin
                    sm_line_q <= sm_line_q + LCNT_W'(1);
                end
            end
            if (wr_first_c || rd_first_c) begin
                op_base_q <= node_base;
                op_cnt_q  <= LCNT_W'(1);
            end
            if (rd_first_c) begin
                rd_nlines_q <= nlines_cur;
                rd_tag_q    <= req_if.req_pe_tag;
            end
            // Saturate so a long overflowing burst never wraps back into the node.
            if (wb_beat_c && op_cnt_q < LCNT_W'(LINES_PER_NODE)) op_cnt_q <= op_cnt_q + LCNT_W'(1);
            if (state_q == RD) op_cnt_q <= op_cnt_q + LCNT_W'(1);
            if (ovf_set_c) ovf_q <= 1'b1;
        end
    end

    // Read-return stage: flags travel alongside the SRAM's one-cycle latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld_q  <= 1'b0;
            out_pe_q   <= 1'b0;
            out_sos_q  <= 1'b0;
            out_eos_q  <= 1'b0;
            out_addr_q <= '0;
            out_tag_q  <= '0;
        end else begin
            out_vld_q  <= issue_c;
            out_pe_q   <= issue_pe_c;
            out_sos_q  <= issue_sos_c;
            out_eos_q  <= issue_eos_c;
            out_addr_q <= addr_c;
            out_tag_q  <= issue_tag_c;
        end
    end

    assign req_if.req_ready = req_ready_c;

    assign sram_cen   = cen_c;
    assign sram_wen   = wen_c;
    assign sram_addr  = addr_c;
    assign sram_wdata = wdata_c;

    // Data is gated by valid so idle and reset cycles present zeros.
    assign sm_valid = out_vld_q & ~out_pe_q;
    assign sm_sos   = sm_valid & out_sos_q;
    assign sm_eos   = sm_valid & out_eos_q;
    assign sm_addr  = sm_valid ? out_addr_q : '0;
    assign sm_data  = sm_valid ? sram_rdata : '0;

    assign pe_valid = out_vld_q & out_pe_q;
    assign pe_sos   = pe_valid & out_sos_q;
    assign pe_eos   = pe_valid & out_eos_q;
    assign pe_tag   = pe_valid ? out_tag_q : '0;
    assign pe_data  = pe_valid ? sram_rdata : '0;

    assign wr_overflow = ovf_q;
    assign busy        = (state_q != IDLE) | out_vld_q;

endmodule

// File: tb/tb_fv_bank_cntl_param.sv
// Self-checking bench for fv_bank_cntl_param with default parameters.
// Expected SRAM strobes and output beats are queued when stimulus is applied and
// popped by a negedge monitor; inputs change 2 time units after the rising edge.
module tb_fv_bank_cntl_param;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 10;
    localparam int NODE_W  = 8;
    localparam int ITER_W  = 4;
    localparam int FVNUM_W = 5;
    localparam int TAG_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [ITER_W-1:0]  replay_iter;
    logic               update_phase;
    logic [FVNUM_W-1:0] fv_num;
    logic               sram_cen, sram_wen;
    logic [ADDR_W-1:0]  sram_addr;
    logic [DATA_W-1:0]  sram_wdata, sram_rdata;
    logic               sm_valid, sm_sos, sm_eos;
    logic [ADDR_W-1:0]  sm_addr;
    logic [DATA_W-1:0]  sm_data;
    logic               pe_valid, pe_sos, pe_eos;
    logic [TAG_W-1:0]   pe_tag;
    logic [DATA_W-1:0]  pe_data;
    logic               wr_overflow, busy;

    fv_bank_cntl_param_if #(.DATA_W(DATA_W), .NODE_W(NODE_W), .TAG_W(TAG_W)) req_if ();

    fv_bank_cntl_param dut (
        .clk         (clk),
        .reset       (reset),
        .replay_iter (replay_iter),
        .update_phase(update_phase),
        .fv_num      (fv_num),
        .req_if      (req_if),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sm_valid    (sm_valid),
        .sm_sos      (sm_sos),
        .sm_eos      (sm_eos),
        .sm_addr     (sm_addr),
        .sm_data     (sm_data),
        .pe_valid    (pe_valid),
        .pe_sos      (pe_sos),
        .pe_eos      (pe_eos),
        .pe_tag      (pe_tag),
        .pe_data     (pe_data),
        .wr_overflow (wr_overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // SRAM with one cycle read latency, plus the bench's own view of its contents.
    logic [DATA_W-1:0] mem     [0:1023];
    logic [DATA_W-1:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            if (sram_wen === 1'b0) mem[sram_addr] <= sram_wdata;
            else                   sram_rdata     <= mem[sram_addr];
        end
    end

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sram_exp_t;

    typedef struct {
        logic              pe;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic              sos;
        logic              eos;
        logic [DATA_W-1:0] data;
    } out_exp_t;

    typedef struct {
        logic [NODE_W-1:0]  node;
        logic [TAG_W-1:0]   tag;
        logic [FVNUM_W-1:0] fv;
        logic [ADDR_W-1:0]  exp_base;
        int                 exp_lines;
    } rd_vec_t;

    sram_exp_t sram_q[$];
    out_exp_t  out_q[$];
    sram_exp_t se;
    out_exp_t  oe;
    int        n_tests = 0;
    int        n_fail  = 0;
    int        n_acc   = 0;
    bit        mon_en  = 1'b0;
    bit        prev_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sram_cen === 1'b0) begin
                n_acc++;
                check("sram_expected", sram_q.size() != 0, 1);
                if (sram_q.size() != 0) begin
                    se = sram_q.pop_front();
                    check("sram_addr", sram_addr, se.addr);
                    check("sram_wen", sram_wen, !se.wr);
                    if (se.wr) check("sram_wdata", sram_wdata, se.data);
                end
            end
            if (sm_valid === 1'b1 || pe_valid === 1'b1) begin
                check("out_latency", prev_rd, 1);
                check("out_expected", out_q.size() != 0, 1);
                if (out_q.size() != 0) begin
                    oe = out_q.pop_front();
                    if (oe.pe) begin
                        check("pe_valid", pe_valid, 1);
                        check("pe_tag", pe_tag, oe.tag);
                        check("pe_sos", pe_sos, oe.sos);
                        check("pe_eos", pe_eos, oe.eos);
                        check("pe_data", pe_data, oe.data);
                    end else begin
                        check("sm_valid", sm_valid, 1);
                        check("sm_addr", sm_addr, oe.addr);
                        check("sm_sos", sm_sos, oe.sos);
                        check("sm_eos", sm_eos, oe.eos);
                        check("sm_data", sm_data, oe.data);
                    end
                end
            end
        end
        prev_rd = (sram_cen === 1'b0) && (sram_wen === 1'b1);
    end

    // Expected streamed beats for one iteration: 4 nodes of 8 lines each reserved.
    task automatic push_stream(input int iter, input int nlines);
        for (int n = 0; n < 4; n++) begin
            for (int l = 0; l < nlines; l++) begin
                logic [ADDR_W-1:0] a;
                a = ADDR_W'(iter * 32 + n * 8 + l);
                sram_q.push_back('{wr: 1'b0, addr: a, data: '0});
                out_q.push_back('{pe: 1'b0, addr: a, tag: '0, sos: (n == 0 && l == 0),
                                  eos: (n == 3 && l == nlines - 1), data: ref_mem[a]});
            end
        end
    endtask

    // Present one request beat and hold it until it is accepted (bounded).
    task automatic send(input logic wr, input logic [NODE_W-1:0] node, input logic [TAG_W-1:0] tag,
                        input logic [DATA_W-1:0] data, input logic eos);
        int c = 0;
        req_if.req_valid   = 1'b1;
        req_if.req_wr      = wr;
        req_if.req_node_id = node;
        req_if.req_pe_tag  = tag;
        req_if.req_data    = data;
        req_if.req_wr_eos  = eos;
        #1;
        while (req_if.req_ready !== 1'b1 && c < 60) begin
            @(posedge clk);
            #3;
            c++;
        end
        check("req_ready", req_if.req_ready, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        req_if.req_valid  = 1'b0;
        req_if.req_wr_eos = 1'b0;
    endtask

    // Write burst of nbeats to a node; beats past the node's 8 lines are dropped.
    task automatic write_node(input logic [NODE_W-1:0] node, input int nbeats, input int gap_after);
        logic [ADDR_W-1:0] base;
        base = ADDR_W'(node >> 2) << 3;
        for (int b = 0; b < nbeats; b++) begin
            logic [DATA_W-1:0] d;
            d = {$urandom, $urandom};
            if (b == gap_after + 1 && gap_after >= 0) begin
                idle_bus();
                @(posedge clk);
                #2;
            end
            if (b < 8) begin
                sram_q.push_back('{wr: 1'b1, addr: base + ADDR_W'(b), data: d});
                ref_mem[base + ADDR_W'(b)] = d;
            end
            send(1'b1, node, '0, d, b == nbeats - 1);
        end
        idle_bus();
    endtask

    task automatic push_read(input rd_vec_t v);
        for (int l = 0; l < v.exp_lines; l++) begin
            logic [ADDR_W-1:0] a;
            a = v.exp_base + ADDR_W'(l);
            sram_q.push_back('{wr: 1'b0, addr: a, data: '0});
            out_q.push_back('{pe: 1'b1, addr: a, tag: v.tag, sos: (l == 0),
                              eos: (l == v.exp_lines - 1), data: ref_mem[a]});
        end
    endtask

    // Wait (bounded) until every queued expectation is consumed and the block is idle.
    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while ((sram_q.size() != 0 || out_q.size() != 0 || busy !== 1'b0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check({name, "_sram_left"}, sram_q.size(), 0);
        check({name, "_out_left"}, out_q.size(), 0);
        check({name, "_busy"}, busy, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t rv[6];
        int      acc0;

        // node, tag, fv_num, expected base line, expected line count
        rv[0] = '{node: 8'd6,   tag: 2'd3, fv: 5'd16, exp_base: 10'd8,   exp_lines: 8};
        rv[1] = '{node: 8'd6,   tag: 2'd3, fv: 5'd1,  exp_base: 10'd8,   exp_lines: 1};
        rv[2] = '{node: 8'd9,   tag: 2'd1, fv: 5'd5,  exp_base: 10'd16,  exp_lines: 3};
        rv[3] = '{node: 8'd0,   tag: 2'd2, fv: 5'd0,  exp_base: 10'd0,   exp_lines: 8};
        rv[4] = '{node: 8'd255, tag: 2'd0, fv: 5'd31, exp_base: 10'd504, exp_lines: 8};
        rv[5] = '{node: 8'd4,   tag: 2'd2, fv: 5'd2,  exp_base: 10'd8,   exp_lines: 1};

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = {32'(i) * 32'h9E37_79B9, 32'hA500_0000 | 32'(i)};
            ref_mem[i] = {32'(i) * 32'h9E37_79B9, 32'hA500_0000 | 32'(i)};
        end

        reset        = 1'b0;
        update_phase = 1'b0;
        replay_iter  = '0;
        fv_num       = 5'd16;
        idle_bus();
        req_if.req_wr      = 1'b0;
        req_if.req_node_id = '0;
        req_if.req_pe_tag  = '0;
        req_if.req_data    = '0;

        #3;
        check("rst_sram_cen", sram_cen, 1);
        check("rst_sram_wen", sram_wen, 1);
        check("rst_req_ready", req_if.req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sm_valid", sm_valid, 0);
        check("rst_pe_valid", pe_valid, 0);
        check("rst_wr_overflow", wr_overflow, 0);

        // Iteration 0 streams 32 lines after reset release, exactly once.
        repeat (2) @(posedge clk);
        #2;
        push_stream(0, 8);
        mon_en = 1'b1;
        reset  = 1'b1;
        wait_drain("iter0", 200);
        acc0 = n_acc;
        repeat (10) @(posedge clk);
        #2;
        check("iter0_no_restream", n_acc - acc0, 0);

        // Iteration 1 streams 32..63.
        push_stream(1, 8);
        replay_iter = 4'd1;
        wait_drain("iter1", 200);

        // fv_num changed mid-phase takes effect only at the next iteration.
        fv_num = 5'd5;
        acc0   = n_acc;
        repeat (3) @(posedge clk);
        #2;
        check("fv_change_no_stream", n_acc - acc0, 0);
        push_stream(2, 3);
        replay_iter = 4'd2;
        wait_drain("iter2", 200);

        // Request-service phase: writes.
        update_phase = 1'b1;
        @(posedge clk);
        #2;
        check("idle_ready", req_if.req_ready, 1);
        write_node(8'd9, 4, 1);
        wait_drain("wr9", 50);
        check("wr9_overflow", wr_overflow, 0);
        write_node(8'd0, 10, -1);
        wait_drain("wr0", 50);
        check("wr0_overflow", wr_overflow, 1);

        // Back-to-back reads from the vector table.
        for (int i = 0; i < 6; i++) begin
            fv_num = rv[i].fv;
            push_read(rv[i]);
            send(1'b0, rv[i].node, rv[i].tag, '0, 1'b0);
            idle_bus();
        end
        wait_drain("reads", 200);
        check("overflow_sticky", wr_overflow, 1);

        // Asynchronous reset in the middle of a read burst.
        mon_en = 1'b0;
        fv_num = 5'd0;
        send(1'b0, 8'd0, 2'd1, '0, 1'b0);
        idle_bus();
        repeat (3) @(posedge clk);
        #2;
        check("mid_read_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("rr_pe_valid", pe_valid, 0);
        check("rr_pe_tag", pe_tag, 0);
        check("rr_pe_data", pe_data, 0);
        check("rr_sram_cen", sram_cen, 1);
        check("rr_busy", busy, 0);
        check("rr_req_ready", req_if.req_ready, 0);
        check("rr_wr_overflow", wr_overflow, 0);
        sram_q.delete();
        out_q.delete();
        update_phase = 1'b0;
        fv_num       = 5'd16;
        @(posedge clk);
        #2;
        push_stream(2, 8);
        mon_en = 1'b1;
        reset  = 1'b1;
        wait_drain("restart2", 200);

        // Asynchronous reset in the middle of a stream burst.
        mon_en      = 1'b0;
        replay_iter = 4'd3;
        repeat (6) @(posedge clk);
        #2;
        check("mid_stream_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("rs_sm_valid", sm_valid, 0);
        check("rs_sm_sos", sm_sos, 0);
        check("rs_sm_addr", sm_addr, 0);
        check("rs_sm_data", sm_data, 0);
        check("rs_sram_cen", sram_cen, 1);
        check("rs_busy", busy, 0);
        sram_q.delete();
        out_q.delete();
        @(posedge clk);
        #2;
        push_stream(3, 8);
        mon_en = 1'b1;
        reset  = 1'b1;
        wait_drain("restart3", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
